// File: rtl/addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
// The saturation bound helper is only referenced when ADDSUB_SATURATE_EN is defined.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam int SAT_MAX_W = 64;

    // Most positive (negative=0) or most negative (negative=1) two's-complement value of a given width.
    function automatic logic [SAT_MAX_W-1:0] sat_bound(input int width, input logic negative);
        logic [SAT_MAX_W-1:0] msb;
        msb = SAT_MAX_W'(1) << (width - 1);
        return negative ? msb : (msb - SAT_MAX_W'(1));
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple adder slice used once per RUN cycle.
// Also exposes the carry into its top bit so the caller can form signed overflow.
module addsub_digit
    import addsub_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign cout     = c[DIGIT];
    assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement add/sub: DIGIT bits per cycle, LSB digit first, start/ready/done handshake.
// Optional macro ADDSUB_SATURATE_EN clamps the result on signed overflow. WIDTH must be >=2, <=64 and a multiple of DIGIT.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CNT_W-1:0] count_q;
    logic             cin_q;
    logic             ready_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             overflow_q;

    logic [DIGIT-1:0] dig_s;
    logic             dig_cout;
    logic             dig_cmsb;
    logic             last_digit;
    logic [WIDTH-1:0] sum_full;
    logic [WIDTH-1:0] result_d;
    logic             overflow_d;

    addsub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .x        (a_q[DIGIT-1:0]),
        .y        (b_q[DIGIT-1:0]),
        .cin      (cin_q),
        .s        (dig_s),
        .cout     (dig_cout),
        .c_msb_in (dig_cmsb)
    );

    assign last_digit = (count_q == CNT_W'(NDIG - 1));
    assign overflow_d = dig_cout ^ dig_cmsb;

    // Only NDIG-1 digits need storing: the final digit goes straight from the adder into result.
    if (NDIG == 1) begin : g_no_acc
        assign sum_full = dig_s;
    end else begin : g_acc
        logic [WIDTH-DIGIT-1:0] acc_q;
        logic [WIDTH-DIGIT-1:0] acc_d;

        assign sum_full = {dig_s, acc_q};

        if (NDIG == 2) begin : g_one_slot
            assign acc_d = dig_s;
        end else begin : g_shift
            assign acc_d = {dig_s, acc_q[WIDTH-DIGIT-1:DIGIT]};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_q <= '0;
            end else if (state_q == RUN) begin
                acc_q <= acc_d;
            end
        end
    end

`ifdef ADDSUB_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_bound(WIDTH, 1'b0));
    localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_bound(WIDTH, 1'b1));

    // On the last digit b_q[DIGIT-1] is the effective B sign; on overflow it matches A's, giving the direction.
    assign result_d = overflow_d ? (b_q[DIGIT-1] ? SAT_NEG : SAT_POS) : sum_full;
`else
    assign result_d = sum_full;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            count_q    <= '0;
            cin_q      <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= (mode == MODE_SUB) ? ~b : b;
                        cin_q   <= (mode == MODE_SUB);
                        count_q <= '0;
                        ready_q <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    cin_q   <= dig_cout;
                    count_q <= count_q + 1'b1;
                    if (last_digit) begin
                        result_q   <= result_d;
                        carry_q    <= dig_cout;
                        overflow_q <= overflow_d;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign result   = result_q;
    assign carry    = carry_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial: directed vector table, handshake corner sequences,
// random ops against a signed-arithmetic reference model, plus sweep instances at other widths.
module tb_addsub_serial;

    localparam int W0    = 16;
    localparam int D0    = 4;
    localparam int NDIG0 = W0 / D0;
    localparam int SWEEP_OPS = 1000;

`ifdef ADDSUB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk;
    logic          rstN;
    logic          start;
    logic          mode;
    logic [W0-1:0] a;
    logic [W0-1:0] b;
    logic          ready;
    logic          done;
    logic [W0-1:0] result;
    logic          carry;
    logic          overflow;

    int testsRun;
    int testsFailed;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    addsub_serial #(
        .WIDTH (W0),
        .DIGIT (D0)
    ) dut (
        .clk      (clk),
        .rst_n    (rstN),
        .start    (start),
        .mode     (mode),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .done     (done),
        .result   (result),
        .carry    (carry),
        .overflow (overflow)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Reference: plain modular sum for result/carry, true signed arithmetic for overflow and clamping.
    function automatic void refModel(input int w, input logic m, input logic [63:0] x, input logic [63:0] y,
                                     output logic [63:0] r, output logic c, output logic v);
        logic [63:0] mask;
        logic [63:0] full;
        longint sx, sy, sr, maxV, minV;
        mask = (64'd1 << w) - 64'd1;
        full = m ? (x + ((~y) & mask) + 64'd1) : (x + y);
        r    = full & mask;
        c    = full[w];
        sx   = x[w-1] ? (longint'(x) - longint'(64'd1 << w)) : longint'(x);
        sy   = y[w-1] ? (longint'(y) - longint'(64'd1 << w)) : longint'(y);
        sr   = m ? (sx - sy) : (sx + sy);
        maxV = longint'(64'd1 << (w - 1)) - 1;
        minV = -longint'(64'd1 << (w - 1));
        v    = (sr > maxV) || (sr < minV);
`ifdef ADDSUB_SATURATE_EN
        if (v) r = (sr > maxV) ? 64'(maxV) : (64'd1 << (w - 1));
`endif
    endfunction

    // Raise start at a negedge and count negedges until done; done is expected at count NDIG+1.
    task automatic applyStimulus(input logic m, input logic [W0-1:0] x, input logic [W0-1:0] y,
                                 output logic [W0-1:0] r, output logic c, output logic v,
                                 output int lat, output bit readyBad);
        int guard;
        guard = 0;
        while (!ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        mode     = m;
        a        = x;
        b        = y;
        start    = 1'b1;
        lat      = 0;
        readyBad = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            if (ready) readyBad = 1'b1;
        end while (!done && lat < 100);
        r = result;
        c = carry;
        v = overflow;
    endtask

    typedef struct {
        logic          m;
        logic [W0-1:0] x;
        logic [W0-1:0] y;
        logic [W0-1:0] r;
        logic          c;
        logic          v;
    } vec_t;

    vec_t vecs[9];

    // Other (WIDTH, DIGIT) points, each with its own reset and random stream.
    localparam int SW[3] = '{8, 8, 32};
    localparam int SD[3] = '{1, 8, 4};

    for (genvar g = 0; g < 3; g++) begin : gSweep
        localparam int W    = SW[g];
        localparam int D    = SD[g];
        localparam int NDIG = W / D;

        logic         swRstN;
        logic         swStart;
        logic         swMode;
        logic [W-1:0] swA;
        logic [W-1:0] swB;
        logic         swReady;
        logic         swDone;
        logic [W-1:0] swRes;
        logic         swCarry;
        logic         swOvf;
        bit           finished;

        addsub_serial #(
            .WIDTH (W),
            .DIGIT (D)
        ) dutSweep (
            .clk      (clk),
            .rst_n    (swRstN),
            .start    (swStart),
            .mode     (swMode),
            .a        (swA),
            .b        (swB),
            .ready    (swReady),
            .done     (swDone),
            .result   (swRes),
            .carry    (swCarry),
            .overflow (swOvf)
        );

        initial begin : sweepRun
            int           lat;
            int           guard;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rm;
            logic [63:0]  eRes;
            logic         eC;
            logic         eV;
            finished = 1'b0;
            swRstN   = 1'b0;
            swStart  = 1'b0;
            swMode   = 1'b0;
            swA      = '0;
            swB      = '0;
            repeat (3) @(negedge clk);
            swRstN = 1'b1;
            @(negedge clk);
            for (int n = 0; n < SWEEP_OPS; n++) begin
                ra = W'($urandom);
                rb = W'($urandom);
                if ($urandom_range(0, 7) == 0) ra = {1'b0, {(W-1){1'b1}}};
                if ($urandom_range(0, 7) == 0) rb = {1'b1, {(W-1){1'b0}}};
                rm = 1'($urandom_range(0, 1));
                guard = 0;
                while (!swReady && guard < 50) begin
                    @(negedge clk);
                    guard++;
                end
                swA     = ra;
                swB     = rb;
                swMode  = rm;
                swStart = 1'b1;
                lat     = 0;
                do begin
                    @(negedge clk);
                    lat++;
                    swStart = 1'b0;
                end while (!swDone && lat < 100);
                refModel(W, rm, 64'(ra), 64'(rb), eRes, eC, eV);
                checkOutput($sformatf("sweep W%0d D%0d a=%0h b=%0h m=%0b", W, D, ra, rb, rm),
                            64'({swRes, swCarry, swOvf}), 64'({eRes[W-1:0], eC, eV}));
                checkOutput($sformatf("sweep W%0d D%0d latency", W, D), 64'(lat), 64'(NDIG + 1));
            end
            finished = 1'b1;
        end
    end

    initial begin : mainTest
        logic [W0-1:0] r;
        logic          c;
        logic          v;
        int            lat;
        bit            readyBad;
        int            guard;
        int            k;
        int            cyc;
        int            lastDone;
        bit            doneSeen;
        logic [W0-1:0] opA[3];
        logic [W0-1:0] opB[3];
        logic          opM[3];
        logic [63:0]   eRes;
        logic          eC;
        logic          eV;
        logic [W0-1:0] ra;
        logic [W0-1:0] rb;
        logic          rm;
        logic [W0-1:0] corners[5];

        testsRun    = 0;
        testsFailed = 0;
        rstN  = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        a     = '0;
        b     = '0;

        vecs[0] = '{1'b0, 16'h0003, 16'h0005, 16'h0008, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 16'h000A, 16'h000A, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 16'h0002, 16'h0007, 16'hFFFB, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 16'h7FFF, 16'h0001, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 16'h8000, 16'h0001, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 16'h8000, 16'h8000, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 16'h0000, 16'h8000, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        checkOutput("reset ready/done", 64'({ready, done}), 64'(2'b10));
        checkOutput("reset result/carry/ovf", 64'({result, carry, overflow}), 64'(0));
        rstN = 1'b1;
        @(negedge clk);

        // Directed table, including the wrap/overflow boundaries.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].m, vecs[i].x, vecs[i].y, r, c, v, lat, readyBad);
            checkOutput($sformatf("vec%0d result", i), 64'(r), 64'(vecs[i].r));
            checkOutput($sformatf("vec%0d carry", i), 64'(c), 64'(vecs[i].c));
            checkOutput($sformatf("vec%0d overflow", i), 64'(v), 64'(vecs[i].v));
            checkOutput($sformatf("vec%0d latency", i), 64'(lat), 64'(NDIG0 + 1));
            if (i == 0) begin
                checkOutput("vec0 ready low while busy", 64'(readyBad), 64'(0));
                @(negedge clk);
                checkOutput("vec0 ready after done", 64'({ready, done}), 64'(2'b10));
            end
        end

        // Starts during RUN and DONE must be ignored; outputs hold previous result during RUN.
        guard = 0;
        while (!ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        mode = 1'b0; a = 16'h1111; b = 16'h2222; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkOutput("hold result during RUN", 64'(result), 64'(vecs[8].r));
        mode = 1'b1; a = 16'h0F0F; b = 16'h0101; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 3;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("ignored-start latency", 64'(lat), 64'(NDIG0 + 1));
        a = 16'hAAAA; b = 16'h5555; start = 1'b1;
        checkOutput("ignored-start result", 64'({result, carry, overflow}), 64'({16'h3333, 1'b0, 1'b0}));
        @(negedge clk);
        start = 1'b0;
        doneSeen = 1'b0;
        repeat (NDIG0 + 3) begin
            @(negedge clk);
            if (done || !ready) doneSeen = 1'b1;
        end
        checkOutput("no op from DONE-cycle start", 64'(doneSeen), 64'(0));
        checkOutput("result held in IDLE", 64'(result), 64'(16'h3333));

        // start held high: back-to-back operations every NDIG+2 cycles.
        opA = '{16'h0001, 16'h8000, 16'h00FF};
        opB = '{16'h0002, 16'h0001, 16'h0100};
        opM = '{1'b0, 1'b1, 1'b1};
        mode = opM[0]; a = opA[0]; b = opB[0]; start = 1'b1;
        k = 0; cyc = 0; lastDone = 0;
        while (k < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                refModel(W0, opM[k], 64'(opA[k]), 64'(opB[k]), eRes, eC, eV);
                checkOutput($sformatf("b2b op%0d", k), 64'({result, carry, overflow}),
                            64'({eRes[W0-1:0], eC, eV}));
                if (k > 0) checkOutput($sformatf("b2b interval %0d", k), 64'(cyc - lastDone), 64'(NDIG0 + 2));
                lastDone = cyc;
                k++;
                if (k < 3) begin
                    mode = opM[k]; a = opA[k]; b = opB[k];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checkOutput("b2b ops completed", 64'(k), 64'(3));

        // Reset asserted mid-RUN at count=2 after an op that left nonzero flags.
        applyStimulus(1'b1, 16'h8000, 16'h0001, r, c, v, lat, readyBad);
        @(negedge clk);
        mode = 1'b0; a = 16'h1234; b = 16'h1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b0;
        #1;
        checkOutput("async reset outputs", 64'({result, carry, overflow}), 64'(0));
        checkOutput("async reset ready/done", 64'({ready, done}), 64'(2'b10));
        doneSeen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done) doneSeen = 1'b1;
        end
        rstN = 1'b1;
        repeat (NDIG0 + 3) begin
            @(negedge clk);
            if (done) doneSeen = 1'b1;
        end
        checkOutput("no done after abort", 64'(doneSeen), 64'(0));
        checkOutput("ready after abort", 64'(ready), 64'(1));
        applyStimulus(1'b0, 16'hFFFF, 16'h0001, r, c, v, lat, readyBad);
        checkOutput("post-reset op", 64'({r, c, v}), 64'({16'h0000, 1'b1, 1'b0}));
        checkOutput("post-reset latency", 64'(lat), 64'(NDIG0 + 1));

        // Random ops on the default configuration, biased towards boundary operands.
        corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
        for (int n = 0; n < 200; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W0'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W0'($urandom);
            rm = 1'($urandom_range(0, 1));
            applyStimulus(rm, ra, rb, r, c, v, lat, readyBad);
            refModel(W0, rm, 64'(ra), 64'(rb), eRes, eC, eV);
            checkOutput($sformatf("rand a=%0h b=%0h m=%0b", ra, rb, rm), 64'({r, c, v}),
                        64'({eRes[W0-1:0], eC, eV}));
        end

        guard = 0;
        while (!(gSweep[0].finished && gSweep[1].finished && gSweep[2].finished) && guard < 50000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("sweeps completed", 64'({gSweep[0].finished, gSweep[1].finished, gSweep[2].finished}),
                    64'(3'b111));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
